// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM channel port arbiter: FSM state encoding and
// the request record captured at grant time.
package sdram_arb_pkg;

    // Address width carried by the latched request record; the top-level
    // ADDR_W defaults to this and must not exceed it.
    localparam int ARB_ADDR_W = 25;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [7:0]            din;
    } arb_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational grant picker: round-robin starting after the pointer, or
// fixed priority with index 0 highest.
module rr_picker #(
    parameter int N_REQ      = 4,
    parameter int FIXED_PRIO = 0,
    parameter int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (FIXED_PRIO != 0) begin
                cand = IDX_W'(k);
            end else begin
                cand = IDX_W'((int'(ptr) + 1 + k) % N_REQ);
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one 8-bit SDRAM channel among N_REQ level-handshake requesters,
// converting grants into edge-triggered rd/wr strobes with an accept watchdog.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int FIXED_PRIO  = 0,
    parameter int ACC_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0][7:0]        req_din,
    output logic [N_REQ-1:0]             ack,
    output logic [7:0]                   rdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [7:0]                   mem_din,
    input  logic [7:0]                   mem_dout,
    input  logic                         mem_busy,
    output logic [7:0]                   retry_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(ACC_TIMEOUT + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic             cur_we;
    logic [WD_W-1:0]  wdog;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    arb_req_t         sel;

    rr_picker #(
        .N_REQ      (N_REQ),
        .FIXED_PRIO (FIXED_PRIO),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    always_comb begin
        sel.we   = req_we[pick_idx];
        sel.addr = ARB_ADDR_W'(req_addr[pick_idx]);
        sel.din  = req_din[pick_idx];
    end

    // Strobes are registered and only ever high in ISSUE, so the channel sees
    // a clean rising edge per attempt and a low gap before any re-issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= IDX_W'(N_REQ - 1);
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            cur_we     <= 1'b0;
            wdog       <= '0;
            ack        <= '0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid && !mem_busy) begin
                        gnt_idx    <= pick_idx;
                        gnt_onehot <= pick_onehot;
                        cur_we     <= sel.we;
                        mem_addr   <= ADDR_W'(sel.addr);
                        mem_din    <= sel.din;
                        mem_wr     <= sel.we;
                        mem_rd     <= ~sel.we;
                        wdog       <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_busy) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= WAIT;
                    end else if (wdog == WD_W'(ACC_TIMEOUT - 1)) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (retry_cnt != 8'hFF) begin
                            retry_cnt <= retry_cnt + 8'd1;
                        end
                        state <= GAP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                GAP: begin
                    mem_wr <= cur_we;
                    mem_rd <= ~cur_we;
                    wdog   <= '0;
                    state  <= ISSUE;
                end
                WAIT: begin
                    if (!mem_busy) begin
                        if (!cur_we) begin
                            rdata <= mem_dout;
                        end
                        ack   <= gnt_onehot;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (FIXED_PRIO == 0) begin
                        ptr <= gnt_idx;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a round-robin and a fixed-priority
// instance, each driving a small SDRAM channel model that returns addr+0xA4.
module tb_sdram_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]        req      [2];
    logic [3:0]        req_we   [2];
    logic [3:0][24:0]  req_addr [2];
    logic [3:0][7:0]   req_din  [2];
    logic [3:0]        ack      [2];
    logic [7:0]        rdata    [2];
    logic [24:0]       mem_addr [2];
    logic              mem_rd   [2];
    logic              mem_wr   [2];
    logic [7:0]        mem_din  [2];
    logic [7:0]        retry_cnt[2];
    int                ch_b       [2];
    int                ignore_req [2];

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic       busy_m   = 1'b0;
        logic [7:0] dout_m   = 8'h00;
        logic       strobe_q = 1'b0;
        int         cnt_m    = 0;
        int         ignored  = 0;
        logic       busy_prev        = 1'b0;
        logic       overlap_seen     = 1'b0;
        logic       strobe_busy_seen = 1'b0;

        sdram_port_arbiter #(
            .N_REQ       (4),
            .ADDR_W      (25),
            .FIXED_PRIO  (gi),
            .ACC_TIMEOUT (15)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .req       (req[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_din   (req_din[gi]),
            .ack       (ack[gi]),
            .rdata     (rdata[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_rd    (mem_rd[gi]),
            .mem_wr    (mem_wr[gi]),
            .mem_din   (mem_din[gi]),
            .mem_dout  (dout_m),
            .mem_busy  (busy_m),
            .retry_cnt (retry_cnt[gi])
        );

        // Channel model: accepts a strobe rising edge (unless told to miss it)
        // and stays busy for ch_b cycles starting the cycle after.
        always @(posedge clk) begin
            strobe_q <= mem_rd[gi] | mem_wr[gi];
            if (busy_m) begin
                if (cnt_m == 0) busy_m <= 1'b0;
                else cnt_m <= cnt_m - 1;
            end else if ((mem_rd[gi] | mem_wr[gi]) && !strobe_q) begin
                if (ignored < ignore_req[gi]) begin
                    ignored <= ignored + 1;
                end else begin
                    busy_m <= 1'b1;
                    cnt_m  <= ch_b[gi] - 1;
                    if (mem_rd[gi]) dout_m <= mem_addr[gi][7:0] + 8'hA4;
                end
            end
        end

        always @(negedge clk) begin
            if (mem_rd[gi] && mem_wr[gi]) overlap_seen <= 1'b1;
            if ((mem_rd[gi] || mem_wr[gi]) && busy_prev) strobe_busy_seen <= 1'b1;
            busy_prev <= busy_m;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ack[i], mem_rd[i], mem_wr[i]} !== 6'b0)
                $display("[TB] FAIL reset_strobes inst%0d: got %b expected 0", i, {ack[i], mem_rd[i], mem_wr[i]});
            else n_pass++;
            n_checks++;
            if ({mem_addr[i], mem_din[i], rdata[i], retry_cnt[i]} !== 49'd0)
                $display("[TB] FAIL reset_data inst%0d: got %h expected 0", i, {mem_addr[i], mem_din[i], rdata[i], retry_cnt[i]});
            else n_pass++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int ack_cyc = -1, rd_first = -1, rd_cyc = 0;
        logic [7:0] d_at_ack = 8'h00;
        logic [24:0] a_seen = '0;
        logic ack_after;
        req_we[0][1] = 1'b0; req_addr[0][1] = 25'h000101; req[0][1] = 1'b1;
        for (int s = 1; s <= 20 && ack_cyc < 0; s++) begin
            @(negedge clk);
            if (mem_rd[0]) begin
                rd_cyc++;
                if (rd_first < 0) begin rd_first = s; a_seen = mem_addr[0]; end
            end
            if (ack[0][1]) begin ack_cyc = s; d_at_ack = rdata[0]; req[0][1] = 1'b0; end
        end
        req[0][1] = 1'b0;
        @(negedge clk);
        ack_after = |ack[0];
        n_checks++; if (rd_first !== 1) $display("[TB] FAIL read_strobe_rise: got %0d expected 1", rd_first); else n_pass++;
        n_checks++; if (rd_cyc !== 2) $display("[TB] FAIL read_strobe_width: got %0d expected 2", rd_cyc); else n_pass++;
        n_checks++; if (a_seen !== 25'h000101) $display("[TB] FAIL read_addr: got %h expected 000101", a_seen); else n_pass++;
        n_checks++; if (ack_cyc !== 9) $display("[TB] FAIL read_ack_latency: got %0d expected 9", ack_cyc); else n_pass++;
        n_checks++; if (d_at_ack !== 8'hA5) $display("[TB] FAIL read_rdata: got %h expected a5", d_at_ack); else n_pass++;
        n_checks++; if (ack_after !== 1'b0) $display("[TB] FAIL ack_one_cycle: got %b expected 0", ack_after); else n_pass++;
    endtask

    task automatic test_write();
        int ack_cyc = -1;
        logic wr_seen = 1'b0, rd_seen = 1'b0;
        logic [7:0] din_seen = 8'h00, d_at_ack = 8'h00;
        req_we[0][2] = 1'b1; req_addr[0][2] = 25'h000222; req_din[0][2] = 8'h3C; req[0][2] = 1'b1;
        for (int s = 1; s <= 20 && ack_cyc < 0; s++) begin
            @(negedge clk);
            if (mem_rd[0]) rd_seen = 1'b1;
            if (mem_wr[0]) begin wr_seen = 1'b1; din_seen = mem_din[0]; end
            if (ack[0][2]) begin ack_cyc = s; d_at_ack = rdata[0]; req[0][2] = 1'b0; end
        end
        req[0][2] = 1'b0;
        n_checks++; if ({wr_seen, rd_seen} !== 2'b10) $display("[TB] FAIL write_strobe wr/rd: got %b expected 10", {wr_seen, rd_seen}); else n_pass++;
        n_checks++; if (din_seen !== 8'h3C) $display("[TB] FAIL write_din: got %h expected 3c", din_seen); else n_pass++;
        n_checks++; if (ack_cyc !== 9) $display("[TB] FAIL write_ack_latency: got %0d expected 9", ack_cyc); else n_pass++;
        n_checks++; if (d_at_ack !== 8'hA5) $display("[TB] FAIL write_rdata_held: got %h expected a5", d_at_ack); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ack1 = -1, ack2 = -1, rise2 = -1;
        logic prev = 1'b0;
        logic [7:0] d2 = 8'h00;
        req_we[0][1] = 1'b0; req_addr[0][1] = 25'h000010; req[0][1] = 1'b1;
        for (int s = 1; s <= 40 && ack2 < 0; s++) begin
            @(negedge clk);
            if (ack1 >= 0 && rise2 < 0 && mem_rd[0] && !prev) rise2 = s;
            prev = mem_rd[0];
            if (ack[0][1]) begin
                if (ack1 < 0) ack1 = s;
                else begin ack2 = s; d2 = rdata[0]; req[0][1] = 1'b0; end
            end
        end
        req[0][1] = 1'b0;
        n_checks++; if (ack1 !== 9) $display("[TB] FAIL b2b_first_ack: got %0d expected 9", ack1); else n_pass++;
        n_checks++; if (rise2 !== 11) $display("[TB] FAIL b2b_next_strobe: got %0d expected 11", rise2); else n_pass++;
        n_checks++; if (ack2 !== 19) $display("[TB] FAIL b2b_second_ack: got %0d expected 19", ack2); else n_pass++;
        n_checks++; if (d2 !== 8'hB4) $display("[TB] FAIL b2b_rdata: got %h expected b4", d2); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n_ack = 0, idx;
        logic [7:0] exp_d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_we[0][i] = 1'b0; req_addr[0][i] = 25'(i * 16 + 1);
        end
        req[0] = 4'hF;
        for (int c = 0; c < 200 && n_ack < 8; c++) begin
            @(negedge clk);
            if (ack[0] != 4'b0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (ack[0][i]) idx = (idx < 0) ? i : 99;
                exp_d = 8'((n_ack % 4) * 16 + 1 + 164);
                n_checks++;
                if (idx !== n_ack % 4) $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", n_ack, idx, n_ack % 4); else n_pass++;
                n_checks++;
                if (rdata[0] !== exp_d) $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", n_ack, rdata[0], exp_d); else n_pass++;
                n_ack++;
                if (n_ack == 8) req[0] = 4'h0;
            end
        end
        req[0] = 4'h0;
        n_checks++; if (n_ack !== 8) $display("[TB] FAIL rr_ack_count: got %0d expected 8", n_ack); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        int n_ack = 0, idx, exp_idx;
        for (int i = 0; i < 4; i++) begin
            req_we[1][i] = 1'b0; req_addr[1][i] = 25'(i * 16 + 1);
        end
        req[1] = 4'hF;
        for (int c = 0; c < 150 && n_ack < 5; c++) begin
            @(negedge clk);
            if (ack[1] != 4'b0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (ack[1][i]) idx = (idx < 0) ? i : 99;
                exp_idx = (n_ack < 4) ? 0 : 1;
                n_checks++;
                if (idx !== exp_idx) $display("[TB] FAIL fp_order[%0d]: got %0d expected %0d", n_ack, idx, exp_idx); else n_pass++;
                n_ack++;
                if (n_ack == 4) req[1][0] = 1'b0;
                if (n_ack == 5) begin
                    n_checks++;
                    if (rdata[1] !== 8'hB5) $display("[TB] FAIL fp_rdata: got %h expected b5", rdata[1]); else n_pass++;
                    req[1] = 4'h0;
                end
            end
        end
        req[1] = 4'h0;
        n_checks++; if (n_ack !== 5) $display("[TB] FAIL fp_ack_count: got %0d expected 5", n_ack); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_watchdog();
        int ack_cyc = -1, busy_early = 0;
        logic [2:0] rd_pat = 3'b000;
        logic [7:0] d_at_ack = 8'h00, retry_at_ack = 8'h00;
        ignore_req[0] = g_inst[0].ignored + 1;
        req_we[0][3] = 1'b0; req_addr[0][3] = 25'h000003; req[0][3] = 1'b1;
        for (int s = 1; s <= 40 && ack_cyc < 0; s++) begin
            @(negedge clk);
            if (s <= 15 && g_inst[0].busy_m) busy_early++;
            if (s == 15) rd_pat[2] = mem_rd[0];
            if (s == 16) rd_pat[1] = mem_rd[0];
            if (s == 17) rd_pat[0] = mem_rd[0];
            if (ack[0][3]) begin
                ack_cyc = s; d_at_ack = rdata[0]; retry_at_ack = retry_cnt[0]; req[0][3] = 1'b0;
            end
        end
        req[0][3] = 1'b0;
        n_checks++; if (busy_early !== 0) $display("[TB] FAIL wd_busy_low: got %0d busy cycles expected 0", busy_early); else n_pass++;
        n_checks++; if (rd_pat !== 3'b101) $display("[TB] FAIL wd_gap_pattern: got %b expected 101", rd_pat); else n_pass++;
        n_checks++; if (retry_at_ack !== 8'd1) $display("[TB] FAIL wd_retry_cnt: got %0d expected 1", retry_at_ack); else n_pass++;
        n_checks++; if (ack_cyc !== 25) $display("[TB] FAIL wd_ack_latency: got %0d expected 25", ack_cyc); else n_pass++;
        n_checks++; if (d_at_ack !== 8'hA7) $display("[TB] FAIL wd_rdata: got %h expected a7", d_at_ack); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int first_rd = -1, ack_cyc = -1;
        logic busy_at4 = 1'b0;
        logic [7:0] d_at_ack = 8'h00;
        req_we[0][1] = 1'b0; req_addr[0][1] = 25'h000020; req[0][1] = 1'b1;
        repeat (4) @(negedge clk);
        busy_at4 = g_inst[0].busy_m;
        reset = 1'b1; req[0][1] = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_at4 !== 1'b1) $display("[TB] FAIL rm_busy_before_reset: got %b expected 1", busy_at4); else n_pass++;
        n_checks++;
        if ({ack[0], mem_rd[0], mem_wr[0]} !== 6'b0)
            $display("[TB] FAIL rm_strobes: got %b expected 0", {ack[0], mem_rd[0], mem_wr[0]});
        else n_pass++;
        n_checks++;
        if ({mem_addr[0], mem_din[0], rdata[0], retry_cnt[0]} !== 49'd0)
            $display("[TB] FAIL rm_data: got %h expected 0", {mem_addr[0], mem_din[0], rdata[0], retry_cnt[0]});
        else n_pass++;
        reset = 1'b0;
        req_we[0][2] = 1'b0; req_addr[0][2] = 25'h000008; req[0][2] = 1'b1;
        for (int s = 6; s <= 40 && ack_cyc < 0; s++) begin
            @(negedge clk);
            if (mem_rd[0] && first_rd < 0) first_rd = s;
            if (ack[0][2]) begin ack_cyc = s; d_at_ack = rdata[0]; req[0][2] = 1'b0; end
        end
        req[0][2] = 1'b0;
        n_checks++; if (first_rd !== 9) $display("[TB] FAIL rm_first_strobe: got %0d expected 9", first_rd); else n_pass++;
        n_checks++; if (ack_cyc !== 17) $display("[TB] FAIL rm_ack_latency: got %0d expected 17", ack_cyc); else n_pass++;
        n_checks++; if (d_at_ack !== 8'hAC) $display("[TB] FAIL rm_rdata: got %h expected ac", d_at_ack); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_strobe_invariants();
        n_checks++;
        if ({g_inst[0].overlap_seen, g_inst[1].overlap_seen} !== 2'b00)
            $display("[TB] FAIL strobe_overlap: got %b expected 00", {g_inst[0].overlap_seen, g_inst[1].overlap_seen});
        else n_pass++;
        n_checks++;
        if ({g_inst[0].strobe_busy_seen, g_inst[1].strobe_busy_seen} !== 2'b00)
            $display("[TB] FAIL strobe_after_busy: got %b expected 00", {g_inst[0].strobe_busy_seen, g_inst[1].strobe_busy_seen});
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; req_we[i] = '0; req_addr[i] = '0; req_din[i] = '0;
            ch_b[i] = 6; ignore_req[i] = 0;
        end
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_round_robin();
        test_fixed_prio();
        test_watchdog();
        test_reset_mid();
        test_strobe_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
